rf_wb_arbiter: RTL and testbench

- Arbitrates the single register-file write port among NUM_REQ writeback sources: 0 = ALU/EX, 1 = LSU load return, 2 = MUL/DIV.
- Uses round-robin selection with a valid/ready handshake per source.
- Drives a registered we/waddr/wdata triple straight into the regfile write port.
- Sits between the writeback stage sources and regfile; the regfile's internal write-to-read bypass sees the registered outputs.

---
 rtl/rf_wb_arbiter_pkg.sv | 19 +
 rtl/rf_wb_arbiter_rr.sv | 40 ++++
 rtl/rf_wb_arbiter.sv | 81 ++++++++
 tb/tb_rf_wb_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared regfile widths and writeback source indices.
// Used by the writeback arbiter and its bench.
package rf_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_NUM    = 32;

    localparam int WB_NUM_SRC = 3;
    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_LSU = 1;
    localparam int WB_SRC_MDU = 2;

    // Width of an index into n requesters (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Combinational round-robin arbiter: one-hot grant to the first
// requester found scanning from i_ptr upward, modulo N.
module rr_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int N = 3
) (
    input  logic                 i_en,
    input  logic [N-1:0]         i_req,
    input  logic [idx_w(N)-1:0]  i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic [idx_w(N)-1:0]  o_idx,
    output logic                 o_any
);

    localparam int PW = idx_w(N);

    logic [PW:0]   w_sum;
    logic [PW-1:0] w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_sum = '0;
        w_j   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(N))
                w_sum = w_sum - (PW+1)'(N);
            w_j = w_sum[PW-1:0];
            if (!o_any && i_en && i_req[w_j]) begin
                o_gnt[w_j] = 1'b1;
                o_idx      = w_j;
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Regfile write-port arbiter: round-robin grant among writeback
// sources, registered we/waddr/wdata with x0 writes filtered out.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = WB_NUM_SRC,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_stall,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      we,
    output logic [ADDR_W-1:0]         waddr,
    output logic [DATA_W-1:0]         wdata,
    output logic [2:0]                grant_id,
    output logic                      wb_busy
);

    localparam int PW = idx_w(NUM_REQ);

    logic [PW-1:0]      r_ptr;
    logic               r_we;
    logic [ADDR_W-1:0]  r_waddr;
    logic [DATA_W-1:0]  r_wdata;
    logic [2:0]         r_gid;

    logic               w_en;
    logic               w_any;
    logic [NUM_REQ-1:0] w_gnt;
    logic [PW-1:0]      w_idx;
    logic [PW-1:0]      w_ptr_nxt;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_data;

    // Reset and stall both suppress grants in the same cycle.
    assign w_en = rst & ~wb_stall;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_en  (w_en),
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_addr    = req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
    assign w_data    = req_data[int'(w_idx)*DATA_W +: DATA_W];
    assign w_ptr_nxt = (w_idx == PW'(NUM_REQ-1)) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_gid   <= '0;
        end else if (w_any) begin
            r_ptr   <= w_ptr_nxt;
            r_we    <= (w_addr != '0);
            r_waddr <= w_addr;
            r_wdata <= w_data;
            r_gid   <= 3'(w_idx);
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign req_ready = w_gnt;
    assign we        = r_we;
    assign waddr     = r_waddr;
    assign wdata     = r_wdata;
    assign grant_id  = r_gid;
    assign wb_busy   = |req_valid;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, round-robin, stall,
// mid-stream reset, single source and x0 write.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        wb_stall;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  grant_id;
    logic        wb_busy;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h2222_1111;
    localparam logic [31:0] D2 = 32'h3333_2222;

    logic [31:0] exp_d [3];
    logic [2:0]  exp_oh [3];

    rf_wb_arbiter u_dut (
        .clk       (clk),
        .rst       (rst),
        .wb_stall  (wb_stall),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .wb_busy   (wb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_d[0] = D0;
        exp_d[1] = D1;
        exp_d[2] = D2;
        exp_oh[0] = 3'b001;
        exp_oh[1] = 3'b010;
        exp_oh[2] = 3'b100;

        // reset held with every source requesting
        rst       = 1'b0;
        wb_stall  = 1'b0;
        req_valid = 3'b111;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_data  = {D2, D1, D0};
        #1;
        chk("rst_ready0", 64'(req_ready), 64'd0);
        tick();
        tick();
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_waddr", 64'(waddr), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        chk("rst_gid", 64'(grant_id), 64'd0);
        chk("busy_all", 64'(wb_busy), 64'd1);

        // release: round-robin 0,1,2,0,1,2
        rst = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("rr_ready", 64'(req_ready), 64'(exp_oh[i%3]));
            tick();
            chk("rr_we", 64'(we), 64'd1);
            chk("rr_waddr", 64'(waddr), 64'((i%3)+1));
            chk("rr_wdata", 64'(wdata), 64'(exp_d[i%3]));
            chk("rr_gid", 64'(grant_id), 64'(i%3));
        end

        // grant to 0 then stall three cycles
        chk("st_pre_ready", 64'(req_ready), 64'b001);
        tick();
        wb_stall = 1'b1;
        #1;
        chk("st_we_done", 64'(we), 64'd1);
        chk("st_gid_done", 64'(grant_id), 64'd0);
        chk("st_ready1", 64'(req_ready), 64'd0);
        tick();
        chk("st_we1", 64'(we), 64'd0);
        chk("st_ready2", 64'(req_ready), 64'd0);
        tick();
        chk("st_we2", 64'(we), 64'd0);
        chk("st_ready3", 64'(req_ready), 64'd0);
        tick();
        chk("st_we3", 64'(we), 64'd0);
        chk("st_hold_gid", 64'(grant_id), 64'd0);
        wb_stall = 1'b0;
        #1;
        chk("st_rel_ready", 64'(req_ready), 64'b010);
        tick();
        chk("st_rel_we", 64'(we), 64'd1);
        chk("st_rel_gid", 64'(grant_id), 64'd1);
        chk("st_rel_waddr", 64'(waddr), 64'd2);
        chk("mr_pre_ready", 64'(req_ready), 64'b100);

        // reset while source 2 is being granted
        rst = 1'b0;
        #1;
        chk("mr_ready", 64'(req_ready), 64'd0);
        tick();
        chk("mr_we", 64'(we), 64'd0);
        chk("mr_gid", 64'(grant_id), 64'd0);
        chk("mr_waddr", 64'(waddr), 64'd0);
        req_valid = 3'b100;
        rst = 1'b1;
        #1;
        chk("mr_regrant", 64'(req_ready), 64'b100);
        tick();
        chk("mr2_we", 64'(we), 64'd1);
        chk("mr2_gid", 64'(grant_id), 64'd2);
        chk("mr2_wdata", 64'(wdata), 64'(D2));

        // single source 1
        req_valid = 3'b010;
        req_addr  = {5'd3, 5'd5, 5'd1};
        req_data  = {D2, 32'hDEAD_BEEF, D0};
        #1;
        chk("ss_ready", 64'(req_ready), 64'b010);
        tick();
        chk("ss_we", 64'(we), 64'd1);
        chk("ss_waddr", 64'(waddr), 64'd5);
        chk("ss_wdata", 64'(wdata), 64'hDEAD_BEEF);
        chk("ss_gid", 64'(grant_id), 64'd1);
        req_valid = 3'b000;
        #1;
        chk("idle_ready", 64'(req_ready), 64'd0);
        chk("idle_busy", 64'(wb_busy), 64'd0);
        tick();
        chk("idle_we", 64'(we), 64'd0);
        chk("idle_waddr", 64'(waddr), 64'd5);
        chk("idle_wdata", 64'(wdata), 64'hDEAD_BEEF);
        chk("idle_gid", 64'(grant_id), 64'd1);

        // x0 write from source 2
        req_valid = 3'b100;
        req_addr  = {5'd0, 5'd2, 5'd1};
        req_data  = {32'h0000_1234, D1, D0};
        #1;
        chk("x0_ready", 64'(req_ready), 64'b100);
        tick();
        chk("x0_we", 64'(we), 64'd0);
        chk("x0_gid", 64'(grant_id), 64'd2);
        chk("x0_wdata", 64'(wdata), 64'h1234);
        req_valid = 3'b111;
        req_addr  = {5'd3, 5'd2, 5'd1};
        #1;
        chk("x0_ptr_wrap", 64'(req_ready), 64'b001);
        tick();
        chk("x0_next_we", 64'(we), 64'd1);
        chk("x0_next_gid", 64'(grant_id), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
